// File: rtl/mem_access_stage.sv
// Memory stage: runs loads/stores over a req/ack handshake and registers results into MEM/WB.
// Non-memory ops take one cycle; memory ops stall upstream until ack or timeout abort.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        byte_access_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic        reg_write_enable_in,
    input  logic        mem_to_reg_select_in,
    input  logic [3:0]  dest_reg_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic        reg_write_enable_out,
    output logic        mem_to_reg_select_out,
    output logic [3:0]  dest_reg_out,
    output logic [31:0] load_data_out,
    output logic [31:0] alu_result_out,
    output logic        mem_fault_out,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        store_q, byte_q, rwe_q, m2r_q;
    logic [31:0] addr_q, data_q;
    logic [3:0]  dest_q;
    logic        mem_op, timeout;
    logic [31:0] lane_shift, load_val;

    assign mem_op  = valid_in & (mem_read_in | mem_write_in);
    assign timeout = (state_q == S_WAIT) & ~dm_ack & (cnt_q == LAST_CNT);

    assign lane_shift = dm_rdata >> {addr_q[1:0], 3'b000};
    assign load_val   = store_q ? 32'd0 : (byte_q ? {24'd0, lane_shift[7:0]} : dm_rdata);

    always_comb begin
        state_d   = state_q;
        stall_out = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = 32'd0;
        dm_wdata  = 32'd0;
        dm_be     = 4'd0;
        case (state_q)
            S_IDLE: begin
                stall_out = mem_op;
                if (mem_op) state_d = S_WAIT;
            end
            S_WAIT: begin
                stall_out = ~dm_ack;
                dm_req    = 1'b1;
                dm_we     = store_q;
                dm_addr   = {addr_q[31:2], 2'b00};
                dm_be     = byte_q ? (4'b0001 << addr_q[1:0]) : 4'b1111;
                dm_wdata  = byte_q ? {4{data_q[7:0]}} : data_q;
                if (dm_ack || timeout) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q                 <= 8'd0;
            store_q               <= 1'b0;
            byte_q                <= 1'b0;
            rwe_q                 <= 1'b0;
            m2r_q                 <= 1'b0;
            addr_q                <= 32'd0;
            data_q                <= 32'd0;
            dest_q                <= 4'd0;
            valid_out             <= 1'b0;
            reg_write_enable_out  <= 1'b0;
            mem_to_reg_select_out <= 1'b0;
            dest_reg_out          <= 4'd0;
            load_data_out         <= 32'd0;
            alu_result_out        <= 32'd0;
            mem_fault_out         <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (mem_op) begin
                // A read+write op is treated as a store.
                store_q   <= mem_write_in;
                byte_q    <= byte_access_in;
                rwe_q     <= reg_write_enable_in;
                m2r_q     <= mem_to_reg_select_in;
                addr_q    <= addr_in;
                data_q    <= store_data_in;
                dest_q    <= dest_reg_in;
                cnt_q     <= 8'd0;
                valid_out <= 1'b0;
            end else begin
                valid_out             <= valid_in;
                reg_write_enable_out  <= reg_write_enable_in;
                mem_to_reg_select_out <= mem_to_reg_select_in;
                dest_reg_out          <= dest_reg_in;
                alu_result_out        <= addr_in;
                load_data_out         <= 32'd0;
            end
        end else begin
            if (dm_ack || timeout) begin
                // Ack takes priority over a coincident timeout.
                valid_out             <= 1'b1;
                reg_write_enable_out  <= dm_ack ? rwe_q : 1'b0;
                mem_to_reg_select_out <= m2r_q;
                dest_reg_out          <= dest_q;
                alu_result_out        <= addr_q;
                load_data_out         <= dm_ack ? load_val : 32'd0;
                if (!dm_ack) mem_fault_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
                if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule
